// File: rtl/chunk_serial_adder.sv
// chunk_serial_adder: multi-cycle adder/subtractor that handles CHUNK bits
// per clock, least significant chunk first, with a carry register linking
// the chunks. It uses a start/busy/done handshake, and the result and
// overflow flag stay held until the next accepted start.
module chunk_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // Reject illegal geometries at elaboration time. A bad geometry
    // would otherwise produce partial chunks or a zero cycle count.
    generate
        if ((WIDTH < 1) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : gBadParams
            $error("chunk_serial_adder: need WIDTH >= 1, 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   opA_q;
    logic [WIDTH-1:0]   bEff_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_d;
    logic               carry_q;
    logic               carry_d;
    logic               sub_q;
    logic [CNT_W-1:0]   count_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH:0]     sum_q;
    logic               overflow_q;

    logic [CHUNK-1:0]   chunkA;
    logic [CHUNK-1:0]   chunkB;
    logic [CHUNK:0]     chunkSum;
    logic               ovf_d;
    int                 base;

    // Add the chunk selected by the counter and merge the chunk into a copy of the partial result.
    always_comb begin
        base     = int'(count_q) * CHUNK;
        chunkA   = opA_q[base +: CHUNK];
        chunkB   = bEff_q[base +: CHUNK];
        chunkSum = {1'b0, chunkA} + {1'b0, chunkB} + {{CHUNK{1'b0}}, carry_q};
        result_d = result_q;
        result_d[base +: CHUNK] = chunkSum[CHUNK-1:0];
        carry_d  = chunkSum[CHUNK];
        ovf_d    = (opA_q[WIDTH-1] == bEff_q[WIDTH-1]) && (result_d[WIDTH-1] != opA_q[WIDTH-1]);
    end

    // Control FSM and datapath registers. Subtraction adds ~b with an
    // inverted borrow as the carry-in, and inverts the final carry to
    // report it as a borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
            carry_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opA_q   <= a;
                        bEff_q  <= sub ? ~b : b;
                        carry_q <= sub ? ~cin : cin;
                        sub_q   <= sub;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= carry_d;
                    if (count_q == LAST) begin
                        sum_q      <= {(sub_q ? ~carry_d : carry_d), result_d};
                        overflow_q <= ovf_d;
                        count_q    <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// tb_chunk_serial_adder: scoreboard bench for chunk_serial_adder. It runs
// an 8-bit/2-bit-chunk instance through directed and random operations. It
// also runs three 4-bit instances (chunk sizes 1, 2 and 4) over every
// operand combination. Expected results come from an integer arithmetic model.
module tb_chunk_serial_adder;

    localparam int N8 = 4;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, ovf8;
    logic [8:0] sum8;

    logic       start4, sub4, cin4;
    logic [3:0] a4, b4;
    logic       busy1, done1, ovf1, busy2, done2, ovf2, busy4, done4, ovf4;
    logic [4:0] sum1, sum2, sum4;

    typedef struct {
        logic [16:0] sum;
        logic        ovf;
        int          edgeNo;
    } expT;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [8:0] sum;
        logic       ovf;
    } vecT;

    expT q8[$];
    expT q1[$];
    expT q2[$];
    expT q4[$];

    int compared  = 0;
    int mismatched = 0;
    int cyc       = 0;
    int busyRun8  = 0;

    chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .overflow(ovf8));

    chunk_serial_adder #(.WIDTH(4), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy1), .done(done1), .sum(sum1), .overflow(ovf1));

    chunk_serial_adder #(.WIDTH(4), .CHUNK(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy2), .done(done2), .sum(sum2), .overflow(ovf2));

    chunk_serial_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .overflow(ovf4));

    // Free-running clock and a rising-edge counter used to measure latency.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stop a hung run so that it still reports a failure.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: run did not complete, actual=hung required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Golden model: plain signed/unsigned integer arithmetic on the operands.
    function automatic expT model(input int w, input int ia, input int ib, input int ic,
                                  input int isub, input int edgeNo);
        expT e;
        int  r, sa, sb, sr, half;
        half     = 1 << (w - 1);
        r        = (isub != 0) ? (ia - ib - ic) : (ia + ib + ic);
        e.sum    = 17'(r & ((1 << (w + 1)) - 1));
        sa       = (ia >= half) ? ia - 2 * half : ia;
        sb       = (ib >= half) ? ib - 2 * half : ib;
        sr       = (isub != 0) ? (sa - sb - ic) : (sa + sb + ic);
        e.ovf    = (sr >= half) || (sr < -half);
        e.edgeNo = edgeNo;
        return e;
    endfunction

    // Monitor for the 8-bit instance. It checks sum, overflow, latency and busy length on every done pulse.
    always @(negedge clk) begin
        expT e;
        if (busy8) busyRun8++;
        if (done8) begin
            checkOutput("busyLen8", busyRun8, N8);
            busyRun8 = 0;
            if (q8.size() == 0) begin
                checkOutput("strayDone8", 32'(done8), 32'd0);
            end else begin
                e = q8.pop_front();
                checkOutput("sum8", 32'(sum8), 32'(e.sum));
                checkOutput("ovf8", 32'(ovf8), 32'(e.ovf));
                checkOutput("lat8", cyc - e.edgeNo, N8);
            end
        end
    end

    // Monitor for the 4-bit, 1-bit-chunk instance.
    always @(negedge clk) begin
        expT e;
        if (done1) begin
            if (q1.size() == 0) checkOutput("strayDone1", 32'(done1), 32'd0);
            else begin
                e = q1.pop_front();
                checkOutput("sum4c1", 32'(sum1), 32'(e.sum));
                checkOutput("ovf4c1", 32'(ovf1), 32'(e.ovf));
                checkOutput("lat4c1", cyc - e.edgeNo, 4);
            end
        end
    end

    // Monitor for the 4-bit, 2-bit-chunk instance.
    always @(negedge clk) begin
        expT e;
        if (done2) begin
            if (q2.size() == 0) checkOutput("strayDone2", 32'(done2), 32'd0);
            else begin
                e = q2.pop_front();
                checkOutput("sum4c2", 32'(sum2), 32'(e.sum));
                checkOutput("ovf4c2", 32'(ovf2), 32'(e.ovf));
                checkOutput("lat4c2", cyc - e.edgeNo, 2);
            end
        end
    end

    // Monitor for the 4-bit, full-width-chunk instance.
    always @(negedge clk) begin
        expT e;
        if (done4) begin
            if (q4.size() == 0) checkOutput("strayDone4", 32'(done4), 32'd0);
            else begin
                e = q4.pop_front();
                checkOutput("sum4c4", 32'(sum4), 32'(e.sum));
                checkOutput("ovf4c4", 32'(ovf4), 32'(e.ovf));
                checkOutput("lat4c4", cyc - e.edgeNo, 1);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic icin, input logic isub, input expT e);
        @(negedge clk);
        a8 = ia; b8 = ib; cin8 = icin; sub8 = isub; start8 = 1'b1;
        e.edgeNo = cyc + 1;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic waitIdle8(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (q8.size() == 0) break;
        end
        if (q8.size() != 0) begin
            checkOutput("timeout8", q8.size(), 0);
            q8.delete();
        end
    endtask

    task automatic waitIdle4(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if ((q1.size() + q2.size() + q4.size()) == 0) break;
        end
        if ((q1.size() + q2.size() + q4.size()) != 0) begin
            checkOutput("timeout4", q1.size() + q2.size() + q4.size(), 0);
            q1.delete(); q2.delete(); q4.delete();
        end
    endtask

    vecT vecs[6];

    // Main stimulus sequence.
    initial begin
        expT e;
        logic [7:0] ra, rb;
        logic       rc, rs;

        vecs = '{
            '{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b0},
            '{8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1},
            '{8'h05, 8'h07, 1'b0, 1'b1, 9'h1FE, 1'b0},
            '{8'h80, 8'h01, 1'b0, 1'b1, 9'h07F, 1'b1},
            '{8'h10, 8'h20, 1'b1, 1'b0, 9'h031, 1'b0},
            '{8'h10, 8'h01, 1'b1, 1'b1, 9'h00E, 1'b0}
        };

        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstBusy", 32'(busy8), 32'd0);
        checkOutput("rstDone", 32'(done8), 32'd0);
        checkOutput("rstSum", 32'(sum8), 32'd0);
        checkOutput("rstOvf", 32'(ovf8), 32'd0);
        rst = 1'b0;

        // Directed vectors, each followed by a hold check a few idle cycles later.
        foreach (vecs[k]) begin
            e.sum = 17'(vecs[k].sum);
            e.ovf = vecs[k].ovf;
            e.edgeNo = 0;
            applyStimulus(vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].sub, e);
            a8 = 8'(~vecs[k].a); b8 = 8'h5A; sub8 = ~vecs[k].sub;
            waitIdle8(20);
            repeat (3) @(negedge clk);
            checkOutput("hold8", 32'({ovf8, sum8}), 32'({vecs[k].ovf, vecs[k].sum}));
        end

        // Start held high with operands changing every cycle. An operation is accepted every N+1 cycles.
        for (int j = 0; j < 3 * (N8 + 1); j++) begin
            @(negedge clk);
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            a8 = ra; b8 = rb; cin8 = rc; sub8 = rs; start8 = 1'b1;
            if ((j % (N8 + 1)) == 0)
                q8.push_back(model(8, int'(ra), int'(rb), int'(rc), int'(rs), cyc + 1));
        end
        @(negedge clk);
        start8 = 1'b0;
        waitIdle8(20);

        // Random single operations, with operands scrambled while the operation is in flight.
        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            e = model(8, int'(ra), int'(rb), int'(rc), int'(rs), 0);
            applyStimulus(ra, rb, rc, rs, e);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            waitIdle8(20);
        end

        // Reset during the second RUN cycle aborts the operation with no done pulse.
        e = model(8, 8'h3C, 8'h55, 0, 0, 0);
        applyStimulus(8'h3C, 8'h55, 1'b0, 1'b0, e);
        @(negedge clk);
        rst = 1'b1;
        q8.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        busyRun8 = 0;
        checkOutput("abortBusy", 32'(busy8), 32'd0);
        checkOutput("abortDone", 32'(done8), 32'd0);
        checkOutput("abortSum", 32'(sum8), 32'd0);
        checkOutput("abortOvf", 32'(ovf8), 32'd0);
        repeat (8) @(negedge clk);
        e = model(8, 8'hC8, 8'h64, 1, 1, 0);
        applyStimulus(8'hC8, 8'h64, 1'b1, 1'b1, e);
        waitIdle8(20);

        // Exhaustive sweep of the 4-bit instances over every operand combination.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    for (int is = 0; is < 2; is++) begin
                        @(negedge clk);
                        a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); sub4 = 1'(is); start4 = 1'b1;
                        q1.push_back(model(4, ia, ib, ic, is, cyc + 1));
                        q2.push_back(model(4, ia, ib, ic, is, cyc + 1));
                        q4.push_back(model(4, ia, ib, ic, is, cyc + 1));
                        @(negedge clk);
                        start4 = 1'b0;
                        waitIdle4(20);
                    end
                end
            end
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/chunk_serial_adder.md
Name: chunk_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Processes CHUNK bits per clock, LSB chunk first, with a carry register between chunks.
- Provides a start/busy/done handshake, carry/borrow-in, carry/borrow-out and signed overflow.
- Serves as the area-lean arithmetic unit for datapaths wider than the combinational adders, trading latency for ripple depth.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 1.
- CHUNK, 2, bits processed per cycle; 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0 (compile-time error otherwise).
- N (localparam), WIDTH/CHUNK, number of processing cycles per operation.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  0: add, 1: subtract (a - b - cin); latched at start.
- a  input  WIDTH  operand A; latched at start.
- b  input  WIDTH  operand B; latched at start.
- cin  input  1  carry-in (add) or borrow-in (sub); latched at start.
- busy  output  1  operation in progress.
- done  output  1  single-cycle pulse; sum and overflow are valid.
- sum  output  WIDTH+1  {carry_out or borrow_out, result[WIDTH-1:0]}; held until the next accepted start.
- overflow  output  1  two's-complement signed overflow of result; held with sum.

Behaviour:
- Reset: rst=1 at an edge forces state=IDLE, busy=0, done=0, sum=0, overflow=0, chunk counter=0, carry register=0.
  - Applies from any state. An operation in progress is aborted and no done pulse follows.
- States:
  - IDLE: busy=0, done=0. start=1 -> RUN.
  - RUN: busy=1, done=0. Processes one chunk per edge. After the N-th chunk -> DONE.
  - DONE: busy=0, done=1 for exactly one cycle. start=1 -> RUN; otherwise -> IDLE.
- On an accepted start edge:
  - Latch a and b_eff = sub ? ~b : b.
  - Carry register = sub ? ~cin : cin.
  - Chunk counter = 0. Record sub.
  - Intermediate result bits need not be cleared; sum/overflow outputs are not changed until DONE.
- Each RUN edge i (i = 0..N-1):
  - result[i*CHUNK +: CHUNK] = a[i*CHUNK +: CHUNK] + b_eff[i*CHUNK +: CHUNK] + carry.
  - Carry register = chunk carry-out. Counter increments.
- Final edge (i = N-1):
  - sum[WIDTH-1:0] = result.
  - sum[WIDTH] = add ? carry_out : ~carry_out (borrow).
  - overflow = (a[W-1] == b_eff[W-1]) && (result[W-1] != a[W-1]).
  - State -> DONE.
- Latency: start sampled at edge k -> done=1 in the cycle following edge k+N. busy is high for exactly N cycles.
- Throughput: start held high continuously yields one result per N+1 cycles. A start seen in DONE is accepted at that edge, so busy rises the cycle after done.
- start during RUN is ignored; it is not queued.
- Changes on a, b, sub, cin during RUN have no effect on the in-flight result.
- CHUNK == WIDTH: N=1. The result appears in the cycle after the start edge, with busy high for one cycle.
- Wrap-around: the result is modulo 2^WIDTH; the lost carry/borrow is reported in sum[WIDTH]. No saturation.

Test Plan:
- WIDTH=8, CHUNK=2, add: a=8'hFF, b=8'h01, cin=0 -> done exactly 4 cycles after the start edge, sum=9'h100, overflow=0, busy high 4 cycles. Then a=8'h7F, b=8'h01 -> sum=9'h080, overflow=1.
- Subtract: a=8'h05, b=8'h07, cin=0 -> sum=9'h1FE (borrow=1), overflow=0. Then a=8'h80, b=8'h01 -> sum=9'h07F, overflow=1.
- Carry/borrow-in: add a=8'h10, b=8'h20, cin=1 -> sum=9'h031. Sub a=8'h10, b=8'h01, cin=1 -> sum=9'h00E, overflow=0.
- Handshake: hold start=1 and change a/b every cycle during RUN -> result matches the values latched at acceptance. A start in the DONE cycle starts the next op, giving done pulses 5 cycles apart. sum stays stable between done pulses.
- Reset mid-op: assert rst on the 2nd RUN cycle for 1 cycle -> next cycle busy=0, done=0, sum=0, overflow=0. No done pulse follows. A subsequent start completes normally.
- Exhaustive self-check against the golden model {a+b+cin} / {a-b-cin}, for WIDTH=4 with CHUNK in {1,2,4}, all a, b, cin, sub -> zero mismatches. done latency is N each time.
